// File: rtl/if_fetch_buf.sv
// Instruction-fetch stage: owns the PC, fetches from a 1-cycle ROM and
// buffers returned words for ID behind a valid/ready handshake.
module if_fetch_buf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   pc;
  logic [31:0]   fetch_pc;
  logic          inflight;
  logic          run;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic          valid;
  logic          pop;
  logic          wr;
  logic          issue;
  logic [CW:0]   occ;

  assign valid = (count != '0);
  assign pop   = valid & id_ready_i & ~redirect_i;
  assign wr    = inflight & ~redirect_i;

  // Projected occupancy after this edge; keeps one slot per in-flight fetch
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = run & ~redirect_i & (occ < (CW+1)'(DEPTH));

  assign rom_ce_o   = issue;
  assign rom_addr_o = pc;
  assign id_valid_o = valid;
  assign id_pc_o    = valid ? pc_mem[rd_ptr]   : '0;
  assign id_inst_o  = valid ? inst_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      fetch_pc <= '0;
      inflight <= 1'b0;
      run      <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      run <= 1'b1;
      if (redirect_i) begin
        // Response arriving now belongs to the old path and is dropped
        pc       <= redirect_pc_i;
        inflight <= 1'b0;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          pc       <= pc + 32'd4;
          fetch_pc <= pc;
        end
        if (wr)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(wr) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= rom_data_i;
    end
  end

endmodule
